fsm_1_resp: RTL

Read-side responder (slave end) of the go/rd/ws/ds read handshake driven by `fsm_1`. It accepts a read request on `rd`, inserts a programmable number of wait states on `ws`, then presents data from an internal register file on `rdata`. It holds that data until the initiator signals done on `ds`. It sits between the read controller and the local storage and replaces the free-running `ws` stimulus currently toggled by the bench.

---
 rtl/fsm_1_resp_if.sv | 26 ++
 rtl/fsm_1_resp.sv | 119 +++++++++++
 2 files changed

// File: rtl/fsm_1_resp_if.sv
// Read handshake between the fsm_1 initiator (master) and the read responder (slave).
// Request, wait-state and data-return signals are grouped here; clock, reset and the write port stay outside.
interface fsm_1_resp_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int WS_W   = 4
);
    logic              rd;
    logic              ds;
    logic [ADDR_W-1:0] addr;
    logic [WS_W-1:0]   cfg_ws;
    logic              ws;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              abort;

    modport master (
        output rd, ds, addr, cfg_ws,
        input  ws, rdata, rvalid, abort
    );

    modport slave (
        input  rd, ds, addr, cfg_ws,
        output ws, rdata, rvalid, abort
    );
endinterface

// File: rtl/fsm_1_resp.sv
// Read responder for the go/rd/ws/ds handshake: programmable wait states, then data
// from a local register file held until the initiator strobes ds.
module fsm_1_resp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int WS_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    fsm_1_resp_if.slave       bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_ws, w_ws_nxt;
    logic              r_rvalid, w_rvalid_nxt;
    logic              r_abort, w_abort_nxt;
    logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
    logic [WS_W-1:0]   r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr_q, w_addr_q_nxt;

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [ADDR_W-1:0] w_rd_addr;
    logic [DATA_W-1:0] w_mem_rd;

    // Zero-wait reads fetch straight from the request address; otherwise use the latched one.
    assign w_rd_addr = (r_state == IDLE) ? bus.addr : r_addr_q;
    assign w_mem_rd  = r_mem[w_rd_addr];

    always_comb begin
        w_state_nxt  = r_state;
        w_ws_nxt     = r_ws;
        w_rvalid_nxt = r_rvalid;
        w_abort_nxt  = 1'b0;
        w_rdata_nxt  = r_rdata;
        w_cnt_nxt    = r_cnt;
        w_addr_q_nxt = r_addr_q;
        case (r_state)
            IDLE: begin
                if (bus.rd) begin
                    w_addr_q_nxt = bus.addr;
                    w_cnt_nxt    = bus.cfg_ws;
                    if (bus.cfg_ws == '0) begin
                        w_state_nxt  = DATA;
                        w_rdata_nxt  = w_mem_rd;
                        w_rvalid_nxt = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                        w_ws_nxt    = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!bus.rd) begin
                    w_state_nxt = IDLE;
                    w_ws_nxt    = 1'b0;
                    w_abort_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    if (r_cnt == WS_W'(1)) begin
                        w_state_nxt  = DATA;
                        w_ws_nxt     = 1'b0;
                        w_rdata_nxt  = w_mem_rd;
                        w_rvalid_nxt = 1'b1;
                    end
                end
            end
            DATA: begin
                // rd held high here is ignored; a new request is only taken back in IDLE.
                if (bus.ds) begin
                    w_state_nxt  = IDLE;
                    w_rvalid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_ws_nxt     = 1'b0;
                w_rvalid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ws     <= 1'b0;
            r_rvalid <= 1'b0;
            r_abort  <= 1'b0;
            r_rdata  <= '0;
            r_cnt    <= '0;
            r_addr_q <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ws     <= w_ws_nxt;
            r_rvalid <= w_rvalid_nxt;
            r_abort  <= w_abort_nxt;
            r_rdata  <= w_rdata_nxt;
            r_cnt    <= w_cnt_nxt;
            r_addr_q <= w_addr_q_nxt;
        end
    end

    // Storage is not reset; a same-edge write lands after the read above sampled the old word.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign bus.ws     = r_ws;
    assign bus.rvalid = r_rvalid;
    assign bus.abort  = r_abort;
    assign bus.rdata  = r_rdata;
endmodule
